// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: FSM states, instruction
// field encodings, ALU operation codes and datapath mux selects.
// Optional feature macro: MC_MULT_EN (enables the R-type mult funct).
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_MULT = 6'b011000;

  // ALU operation codes
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLL  = 3'b011;
  localparam logic [2:0] ALU_MULT = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // ALU operand B selects
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_aludec.sv
// Combinational R-type funct decoder: maps funct to the ALU operation code
// and flags whether the funct is a supported operation. Unsupported functs
// return add so the ALU input stays at a benign value.
// Optional feature macro: MC_MULT_EN (decodes the mult funct).
module aludec
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] funct,
  output logic [2:0]     alucontrol,
  output logic           valid
);

  // funct lookup with add as the fallback operation
  always_comb begin
    alucontrol = ALU_ADD;
    valid      = 1'b1;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_NOR:  alucontrol = ALU_NOR;
      FN_SLT:  alucontrol = ALU_SLT;
      FN_SLL:  alucontrol = ALU_SLL;
`ifdef MC_MULT_EN
      FN_MULT: alucontrol = ALU_MULT;
`endif
      default: begin
        alucontrol = ALU_ADD;
        valid      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the 16-bit MIPS-style CPU. Sequences fetch,
// decode, execute, memory and writeback, stalls on mem_ready, and decodes
// the ALU operation and operand selects. Outputs are decoded from the state
// register; FETCH irwrite/pcen follow mem_ready and BRANCH pcen follows
// zeroo. While reset is high all strobes are held low.
// Optional feature macro: MC_MULT_EN (R-type mult support).
module mc_controller
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic [OPW-1:0] funct,
  input  logic           zeroo,
  input  logic           mem_ready,
  output logic [2:0]     alucontrol,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic           pcen,
  output logic           iord,
  output logic           memrd,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           illegal
);

  state_t     state_q, state_d;
  logic [2:0] fn_alu;
  logic       fn_valid;

  aludec #(.OPW(OPW)) u_aludec (
    .funct      (funct),
    .alucontrol (fn_alu),
    .valid      (fn_valid)
  );

  // Next-state selection; memory states wait for mem_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = fn_valid ? S_ALUWB : S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEX:   state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset into FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Output decode from the current state; strobes suppressed during reset
  always_comb begin
    alucontrol = ALU_ADD;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REGB;
    pcsrc      = PCSRC_ALU;
    pcen       = 1'b0;
    iord       = 1'b0;
    memrd      = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        memrd   = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        illegal = !((op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                    (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J));
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        memrd = 1'b1;
        iord  = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWRITE: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = fn_alu;
        illegal    = !fn_valid;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PCSRC_ALUOUT;
        pcen       = zeroo;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc = PCSRC_JUMP;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pcen     = 1'b0;
      memrd    = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Table-driven bench for mc_controller: per-cycle vectors of inputs and
// expected outputs, with expectations queued when a vector is driven and
// compared when the outputs are sampled on the falling edge.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zeroo, mem_ready;
  logic [2:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen, iord, memrd, memwrite, irwrite, regdst, memtoreg, regwrite, illegal;

  always #5 clk = ~clk;

  mc_controller #(.OPW(6)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zeroo(zeroo),
    .mem_ready(mem_ready), .alucontrol(alucontrol), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .iord(iord),
    .memrd(memrd), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .illegal(illegal)
  );

  // Output bundle: alu[16:14] a[13] b[12:11] pcs[10:9] pcen[8] iord[7]
  // memrd[6] memwrite[5] irwrite[4] regdst[3] memtoreg[2] regwrite[1] illegal[0]
  function automatic logic [16:0] pk(input logic [2:0] alu, input logic a,
      input logic [1:0] b, input logic [1:0] pcs, input logic pe, input logic io,
      input logic mr, input logic mw, input logic ir, input logic rd,
      input logic mtr, input logic rw, input logic il);
    return {alu, a, b, pcs, pe, io, mr, mw, ir, rd, mtr, rw, il};
  endfunction

  localparam logic [16:0] ALL = 17'h1FFFF;
  localparam logic [16:0] STR = 17'h00173;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        mr;
    logic [16:0] exp;
    logic [16:0] msk;
    logic [63:0] tag;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] sb_exp[$], sb_msk[$];
  logic [63:0] sb_tag[$];
  int          n_checks = 0;
  int          n_fail = 0;

  logic [16:0] F_W, F_G, DEC, DEC_IL, MADR, MRD, MWB, MWR, ALUWB, BR_T, BR_N,
               AIEX, AIWB, JMP, EX_IL, ZERO;

  task automatic add(input logic rst, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic mr, input logic [16:0] e,
                     input logic [16:0] m, input logic [63:0] t);
    vec_t v;
    v.rst = rst; v.op = o; v.fn = f; v.z = z; v.mr = mr;
    v.exp = e; v.msk = m; v.tag = t;
    vecs.push_back(v);
  endtask

  function automatic logic [16:0] ex(input logic [2:0] alu);
    return pk(alu, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  initial begin
    logic [16:0] act;
    F_W    = pk(3'b010, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    F_G    = pk(3'b010, 0, 2'b01, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    DEC    = pk(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    DEC_IL = pk(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    MADR   = pk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    MRD    = pk(3'b010, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    MWB    = pk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    MWR    = pk(3'b010, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    ALUWB  = pk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    BR_T   = pk(3'b110, 1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    BR_N   = pk(3'b110, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    AIEX   = pk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    AIWB   = pk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    JMP    = pk(3'b010, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    EX_IL  = pk(3'b010, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    ZERO   = 17'h0;

    // power-up reset: only strobes are defined
    add(1, 6'h00, 6'h00, 0, 1, ZERO, STR, "rst0");
    add(1, 6'h00, 6'h00, 0, 1, ZERO, STR, "rst1");
    // lw, five cycles
    add(0, 6'b100011, 6'h00, 0, 1, F_G,   ALL, "lw_f");
    add(0, 6'b100011, 6'h00, 0, 1, DEC,   ALL, "lw_d");
    add(0, 6'b100011, 6'h00, 0, 1, MADR,  ALL, "lw_ma");
    add(0, 6'b100011, 6'h00, 0, 1, MRD,   ALL, "lw_mr");
    add(0, 6'b100011, 6'h00, 0, 1, MWB,   ALL, "lw_wb");
    // sw with fetch wait and two memory wait cycles
    add(0, 6'b101011, 6'h00, 0, 0, F_W,   ALL, "sw_fw");
    add(0, 6'b101011, 6'h00, 0, 1, F_G,   ALL, "sw_f");
    add(0, 6'b101011, 6'h00, 0, 0, DEC,   ALL, "sw_d");
    add(0, 6'b101011, 6'h00, 0, 0, MADR,  ALL, "sw_ma");
    add(0, 6'b101011, 6'h00, 0, 0, MWR,   ALL, "sw_w0");
    add(0, 6'b101011, 6'h00, 0, 0, MWR,   ALL, "sw_w1");
    add(0, 6'b101011, 6'h00, 0, 1, MWR,   ALL, "sw_w2");
    // beq taken / not taken
    add(0, 6'b000100, 6'h00, 1, 1, F_G,   ALL, "beq1_f");
    add(0, 6'b000100, 6'h00, 1, 1, DEC,   ALL, "beq1_d");
    add(0, 6'b000100, 6'h00, 1, 1, BR_T,  ALL, "beq1_b");
    add(0, 6'b000100, 6'h00, 0, 1, F_G,   ALL, "beq0_f");
    add(0, 6'b000100, 6'h00, 0, 1, DEC,   ALL, "beq0_d");
    add(0, 6'b000100, 6'h00, 0, 1, BR_N,  ALL, "beq0_b");
    // R-type nor, sub, slt, sll, and, or
    add(0, 6'h00, 6'b100111, 1, 1, F_G,   ALL, "nor_f");
    add(0, 6'h00, 6'b100111, 1, 1, DEC,   ALL, "nor_d");
    add(0, 6'h00, 6'b100111, 1, 1, ex(3'b101), ALL, "nor_x");
    add(0, 6'h00, 6'b100111, 1, 1, ALUWB, ALL, "nor_wb");
    add(0, 6'h00, 6'b100010, 0, 1, F_G,   ALL, "sub_f");
    add(0, 6'h00, 6'b100010, 0, 1, DEC,   ALL, "sub_d");
    add(0, 6'h00, 6'b100010, 0, 1, ex(3'b110), ALL, "sub_x");
    add(0, 6'h00, 6'b100010, 0, 1, ALUWB, ALL, "sub_wb");
    add(0, 6'h00, 6'b101010, 0, 1, F_G,   ALL, "slt_f");
    add(0, 6'h00, 6'b101010, 0, 1, DEC,   ALL, "slt_d");
    add(0, 6'h00, 6'b101010, 0, 1, ex(3'b111), ALL, "slt_x");
    add(0, 6'h00, 6'b101010, 0, 1, ALUWB, ALL, "slt_wb");
    add(0, 6'h00, 6'b000000, 0, 1, F_G,   ALL, "sll_f");
    add(0, 6'h00, 6'b000000, 0, 1, DEC,   ALL, "sll_d");
    add(0, 6'h00, 6'b000000, 0, 1, ex(3'b011), ALL, "sll_x");
    add(0, 6'h00, 6'b000000, 0, 1, ALUWB, ALL, "sll_wb");
    add(0, 6'h00, 6'b100100, 0, 1, F_G,   ALL, "and_f");
    add(0, 6'h00, 6'b100100, 0, 1, DEC,   ALL, "and_d");
    add(0, 6'h00, 6'b100100, 0, 1, ex(3'b000), ALL, "and_x");
    add(0, 6'h00, 6'b100100, 0, 1, ALUWB, ALL, "and_wb");
    add(0, 6'h00, 6'b100101, 0, 1, F_G,   ALL, "or_f");
    add(0, 6'h00, 6'b100101, 0, 1, DEC,   ALL, "or_d");
    add(0, 6'h00, 6'b100101, 0, 1, ex(3'b001), ALL, "or_x");
    add(0, 6'h00, 6'b100101, 0, 1, ALUWB, ALL, "or_wb");
    // mult funct depends on build option
    add(0, 6'h00, 6'b011000, 0, 1, F_G,   ALL, "mul_f");
    add(0, 6'h00, 6'b011000, 0, 1, DEC,   ALL, "mul_d");
`ifdef MC_MULT_EN
    add(0, 6'h00, 6'b011000, 0, 1, ex(3'b100), ALL, "mul_x");
    add(0, 6'h00, 6'b011000, 0, 1, ALUWB, ALL, "mul_wb");
`else
    add(0, 6'h00, 6'b011000, 0, 1, EX_IL, ALL, "mul_il");
`endif
    // illegal funct then illegal opcode, each returning to FETCH
    add(0, 6'h00, 6'b111111, 0, 1, F_G,   ALL, "badf_f");
    add(0, 6'h00, 6'b111111, 0, 1, DEC,   ALL, "badf_d");
    add(0, 6'h00, 6'b111111, 0, 1, EX_IL, ALL, "badf_x");
    add(0, 6'b111111, 6'h00, 0, 1, F_G,   ALL, "badop_f");
    add(0, 6'b111111, 6'h00, 0, 1, DEC_IL, ALL, "badop_d");
    add(0, 6'b111111, 6'h00, 0, 0, F_W,   ALL, "badop_n");
    // addi and j
    add(0, 6'b001000, 6'h00, 0, 1, F_G,   ALL, "addi_f");
    add(0, 6'b001000, 6'h00, 0, 1, DEC,   ALL, "addi_d");
    add(0, 6'b001000, 6'h00, 0, 1, AIEX,  ALL, "addi_x");
    add(0, 6'b001000, 6'h00, 0, 1, AIWB,  ALL, "addi_wb");
    add(0, 6'b000010, 6'h00, 0, 1, F_G,   ALL, "j_f");
    add(0, 6'b000010, 6'h00, 0, 1, DEC,   ALL, "j_d");
    add(0, 6'b000010, 6'h00, 0, 1, JMP,   ALL, "j_j");
    // reset held three cycles while in EXECUTE with a bad funct
    add(0, 6'h00, 6'b111111, 0, 1, F_G,   ALL, "rx_f");
    add(0, 6'h00, 6'b111111, 0, 1, DEC,   ALL, "rx_d");
    add(1, 6'h00, 6'b111111, 0, 1, ZERO,  STR, "rx_r0");
    add(1, 6'h00, 6'b111111, 0, 1, ZERO,  STR, "rx_r1");
    add(1, 6'h00, 6'b111111, 0, 1, ZERO,  STR, "rx_r2");
    add(0, 6'h00, 6'b111111, 0, 0, F_W,   ALL, "rx_fetch");
    // reset in MEMWB suppresses the register write
    add(0, 6'b100011, 6'h00, 0, 1, F_G,   ALL, "rw_f");
    add(0, 6'b100011, 6'h00, 0, 1, DEC,   ALL, "rw_d");
    add(0, 6'b100011, 6'h00, 0, 1, MADR,  ALL, "rw_ma");
    add(0, 6'b100011, 6'h00, 0, 1, MRD,   ALL, "rw_mr");
    add(1, 6'b100011, 6'h00, 0, 1, ZERO,  STR, "rw_rst");
    add(0, 6'b100011, 6'h00, 0, 1, F_G,   ALL, "rw_fetch");

    reset = 1'b1; op = '0; funct = '0; zeroo = 1'b0; mem_ready = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].fn;
      zeroo = vecs[i].z; mem_ready = vecs[i].mr;
      sb_exp.push_back(vecs[i].exp);
      sb_msk.push_back(vecs[i].msk);
      sb_tag.push_back(vecs[i].tag);
      @(negedge clk);
      act = {alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, memrd, memwrite,
             irwrite, regdst, memtoreg, regwrite, illegal};
      if (sb_exp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard_empty vec=%0d", i);
      end else begin
        logic [16:0] e, m;
        logic [63:0] t;
        e = sb_exp.pop_front(); m = sb_msk.pop_front(); t = sb_tag.pop_front();
        n_checks++;
        if ((act & m) !== (e & m)) begin
          n_fail++;
          $display("FAIL %0s vec=%0d got=%05h want=%05h mask=%05h", t, i, act, e, m);
        end
      end
      n_checks++;
      if (memrd && memwrite) begin
        n_fail++;
        $display("FAIL rd_wr_overlap vec=%0d got=1 want=0", i);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
